s2p_rx: RTL and testbench
=========================

S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 WIDTH, 16, frame width in bits; header included.
REQ-002 HDR, 2'b11, 2-bit sync header occupying frame bits [WIDTH-1:WIDTH-2].
REQ-003 LOCK_CNT, 2, consecutive good frames required before sync_locked asserts.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din  input  1  serial data bit, MSB of frame first.
REQ-007 din_valid  input  1  din qualifier; bit sampled only when high.
REQ-008 dout  output  WIDTH  last complete frame, header included.
REQ-009 dout_valid  output  1  one-cycle pulse: dout updated.
REQ-010 sync_locked  output  1  level: receiver aligned to frame boundaries.
REQ-011 frame_err  output  1  one-cycle pulse: header mismatch while locked.

Function
REQ-012 States SHALL be HUNT, HDR1, DATA; a 4-bit bit counter and a WIDTH-bit shift register SHALL be kept.
REQ-013 Cycles with din_valid=0 SHALL neither shift nor advance the counter or state (stall); outputs hold, pulses deassert.
REQ-014 HUNT: valid din=1 -> HDR1; valid din=0 -> stay HUNT.
REQ-015 HDR1: valid din=1 -> DATA, shift register seeded with HDR, counter=2; valid din=0 -> HUNT.
REQ-016 DATA: each valid bit SHALL shift in at LSB and increment the counter.
REQ-017 Completion: on the valid bit with counter=WIDTH-1, dout SHALL load the assembled frame and dout_valid SHALL pulse in the next cycle (1-cycle latency after 16th bit sampled); counter wraps to 0.
REQ-018 After completion, state SHALL remain DATA with counter=0; the two next valid bits SHALL be compared with HDR.
REQ-019 Header mismatch while in DATA at counter 0 or 1 SHALL return to HUNT and clear the good-frame count; frame_err SHALL pulse only if sync_locked was 1.
REQ-020 Good-frame count SHALL saturate at LOCK_CNT; sync_locked=1 when count=LOCK_CNT, cleared on any mismatch.
REQ-021 Back-to-back frames with no din_valid gaps SHALL be received without lost bits (one frame per 16 valid cycles).
REQ-022 Simultaneous completion and new-frame first bit cannot occur (one bit per cycle); dout SHALL hold until the next completion.
REQ-023 dout SHALL never change except on a completion cycle; partial frames SHALL never appear on dout.

Reset
REQ-024 rst_n low SHALL asynchronously force state=HUNT, counter=0, shift register=0, good-frame count=0.
REQ-025 Reset values: dout=0, dout_valid=0, sync_locked=0, frame_err=0.
REQ-026 Reset mid-frame SHALL discard the partial frame; no dout_valid pulse results from it.
REQ-027 After rst_n rises, the first rising clk edge SHALL operate normally.

Structure
REQ-028 Package s2p_pkg SHALL hold the state enum type, WIDTH default, and HDR constant.
REQ-029 Single module; no sub-module is warranted (shift register, counter and FSM are one cohesive process set).
REQ-030 The block SHALL be bit-compatible with the team's existing P2S transmitter: MSB first, header 2'b11, sig_valid driving din_valid.

Verification
REQ-031 Leading 5 valid zeros, then frame 16'hC5A3 -> dout=16'hC5A3, dout_valid high exactly one cycle after the 16th frame bit, sync_locked=0.
REQ-032 Frames 16'hC001, 16'hFFFF, 16'hD234 back-to-back -> three dout_valid pulses 16 cycles apart; sync_locked=1 from the cycle after the 2nd pulse.
REQ-033 While locked, frame with header 2'b10 (16'h8123) -> frame_err pulse at the 2nd bit, sync_locked=0, state HUNT, no dout_valid.
REQ-034 Frame 16'hE00F with din_valid low for 3 cycles after bit 7 -> dout=16'hE00F, pulse delayed by 3 cycles.
REQ-035 rst_n low after bit 9 of 16'hCAFE, then full 16'hC0DE -> no pulse for the aborted frame; dout=16'hC0DE, all outputs 0 during reset.
REQ-036 Single isolated valid 1 followed by valid 0 -> HUNT re-entered; no dout_valid, no frame_err.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial-to-parallel frame receiver.
// The frame layout matches the P2S transmitter: MSB first, 2-bit sync header on top.
package s2p_pkg;

    localparam int         WIDTH_DEF = 16;
    localparam logic [1:0] HDR       = 2'b11;
    localparam int         LOCK_CNT  = 2;
    localparam int         CNT_W     = 4;
    localparam int         GOOD_W    = 2;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HDR1 = 2'd1,
        DATA = 2'd2
    } state_t;

    // Header bit expected at frame position 0 (MSB of header) or 1.
    function automatic logic hdr_bit(input logic [CNT_W-1:0] cnt);
        hdr_bit = (cnt == {CNT_W{1'b0}}) ? HDR[1] : HDR[0];
    endfunction

endpackage

// File: rtl/s2p_rx.sv
// Serial-to-parallel frame receiver: hunts for the sync header, assembles frames
// MSB first and tracks frame alignment lock.
module s2p_rx
    import s2p_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             sync_locked,
    output logic             frame_err
);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   shift_r, shift_s;
    logic [GOOD_W-1:0]  good_r, good_s;
    logic               done_s, mismatch_s;
    logic [WIDTH-1:0]   dout_r;
    logic               dout_valid_r, sync_locked_r, frame_err_r;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

    // State, bit counter, shift register and good-frame count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HUNT;
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {WIDTH{1'b0}};
            good_r  <= {GOOD_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            good_r  <= good_s;
        end
    end

    // Next-state logic; an invalid cycle is a pure stall.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shift_s = shift_r;
        good_s  = good_r;
        if (din_valid) begin
            case (state_r)
                HUNT: begin
                    if (din) begin
                        state_s = HDR1;
                    end else begin
                        state_s = HUNT;
                    end
                end
                HDR1: begin
                    if (din) begin
                        state_s = DATA;
                        shift_s = {{(WIDTH-2){1'b0}}, HDR};
                        cnt_s   = 4'd2;
                    end else begin
                        state_s = HUNT;
                    end
                end
                DATA: begin
                    if (mismatch_s) begin
                        state_s = HUNT;
                        cnt_s   = {CNT_W{1'b0}};
                        good_s  = {GOOD_W{1'b0}};
                    end else begin
                        shift_s = {shift_r[WIDTH-2:0], din};
                        if (done_s) begin
                            cnt_s  = {CNT_W{1'b0}};
                            good_s = (good_r == GOOD_MAX) ? good_r : good_r + 2'd1;
                        end else begin
                            cnt_s  = cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_s = HUNT;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Per-bit decode: frame completion and header check at positions 0 and 1.
    always_comb begin
        done_s     = 1'b0;
        mismatch_s = 1'b0;
        if (din_valid && (state_r == DATA)) begin
            done_s     = (cnt_r == CNT_LAST);
            mismatch_s = (cnt_r <= 4'd1) && (din != hdr_bit(cnt_r));
        end else begin
            done_s     = 1'b0;
            mismatch_s = 1'b0;
        end
    end

    // Registered outputs; lock follows the good-frame count one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r        <= {WIDTH{1'b0}};
            dout_valid_r  <= 1'b0;
            sync_locked_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            dout_valid_r  <= done_s;
            frame_err_r   <= mismatch_s & sync_locked_r;
            sync_locked_r <= mismatch_s ? 1'b0 : (good_r == GOOD_MAX);
            if (done_s) begin
                dout_r <= {shift_r[WIDTH-2:0], din};
            end
        end
    end

    assign dout        = dout_r;
    assign dout_valid  = dout_valid_r;
    assign sync_locked = sync_locked_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_s2p_rx.sv
// Self-checking bench for s2p_rx: directed frame table, hand-written corner
// sequences and randomized framed traffic against an arithmetic reference model.
module tb_s2p_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic [15:0] dout;
    logic        dout_valid, sync_locked, frame_err;

    s2p_rx dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .sync_locked(sync_locked),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: alignment flag, count of header ones seen while hunting,
    // position within frame and frame value accumulated arithmetically.
    int          m_aligned, m_ones, m_pos, m_acc, m_good;
    logic        m_locked, m_dv, m_err;
    logic [15:0] m_dout;
    logic [1:0]  m_hdr = 2'b11;

    function automatic void model_reset();
        m_aligned = 0; m_ones = 0; m_pos = 0; m_acc = 0; m_good = 0;
        m_locked = 1'b0; m_dv = 1'b0; m_err = 1'b0; m_dout = 16'h0000;
    endfunction

    function automatic void model_step(input logic b, input logic v);
        int g_old;
        bit mis;
        g_old = m_good;
        mis   = 1'b0;
        m_dv  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (m_aligned == 0) begin
                if (b) begin
                    m_ones++;
                    if (m_ones == 2) begin
                        m_aligned = 1; m_pos = 2; m_acc = 3;
                    end
                end else begin
                    m_ones = 0;
                end
            end else if (m_pos < 2 && b != m_hdr[1-m_pos]) begin
                mis = 1'b1;
                m_err = m_locked;
                m_aligned = 0; m_ones = 0; m_good = 0;
            end else begin
                m_acc = m_acc * 2 + int'(b);
                m_pos++;
                if (m_pos == 16) begin
                    m_dout = m_acc[15:0];
                    m_dv = 1'b1;
                    m_pos = 0; m_acc = 0;
                    if (m_good < 2) m_good++;
                end
            end
        end
        m_locked = mis ? 1'b0 : (g_old == 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic step(input logic b, input logic v);
        din = b;
        din_valid = v;
        @(posedge clk);
        model_step(b, v);
        #1;
        cyc++;
        chk("dout", {16'h0000, dout}, {16'h0000, m_dout});
        chk("dout_valid", {31'h0, dout_valid}, {31'h0, m_dv});
        chk("sync_locked", {31'h0, sync_locked}, {31'h0, m_locked});
        chk("frame_err", {31'h0, frame_err}, {31'h0, m_err});
    endtask

    task automatic do_reset();
        din = 1'b0;
        din_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_dout", {16'h0000, dout}, 32'h0);
        chk("rst_pulses", {29'h0, dout_valid, sync_locked, frame_err}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    logic lock_first;

    // Sends one frame MSB first with an optional stall gap after bit index gap_at.
    task automatic send_frame(input logic [15:0] f, input int gap_at, input int gap_len,
                              output int first_pulse, output int npulse);
        int k;
        k = 0;
        first_pulse = -1;
        npulse = 0;
        for (int i = 0; i < 16; i++) begin
            step(f[15-i], 1'b1);
            k++;
            if (i == 0) lock_first = sync_locked;
            if (dout_valid) begin
                npulse++;
                if (first_pulse < 0) first_pulse = k;
            end
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'b1, 1'b0);
                    k++;
                    if (dout_valid) npulse++;
                end
            end
        end
    endtask

    typedef struct {
        logic [15:0] frame;
        int          gap_at;
        int          gap_len;
        logic [15:0] exp_dout;
        int          exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int fp, np, r;
        logic [15:0] f;

        vecs[0] = '{16'hC5A3, -1, 0, 16'hC5A3, 16};
        vecs[1] = '{16'hE00F,  6, 3, 16'hE00F, 19};
        vecs[2] = '{16'hC0DE, -1, 0, 16'hC0DE, 16};
        vecs[3] = '{16'hFFFF,  1, 2, 16'hFFFF, 18};

        model_reset();
        do_reset();

        // Table: leading zeros, one frame, pulse latency, data and no lock.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int z = 0; z < 5; z++) step(1'b0, 1'b1);
            send_frame(vecs[v].frame, vecs[v].gap_at, vecs[v].gap_len, fp, np);
            chk("tbl_lat", fp, vecs[v].exp_lat);
            chk("tbl_npulse", np, 1);
            chk("tbl_dout", {16'h0000, dout}, {16'h0000, vecs[v].exp_dout});
            chk("tbl_unlocked", {31'h0, sync_locked}, 32'h0);
            step(1'b0, 1'b0);
            chk("tbl_pulse_width", {31'h0, dout_valid}, 32'h0);
        end

        // Back-to-back frames reach lock the cycle after the second pulse.
        do_reset();
        send_frame(16'hC001, -1, 0, fp, np);
        chk("b2b_f1_lat", fp, 16);
        send_frame(16'hFFFF, -1, 0, fp, np);
        chk("b2b_f2_lat", fp, 16);
        chk("b2b_lock_at_pulse2", {31'h0, sync_locked}, 32'h0);
        send_frame(16'hD234, -1, 0, fp, np);
        chk("b2b_lock_after_pulse2", {31'h0, lock_first}, 32'h1);
        chk("b2b_f3_lat", fp, 16);
        chk("b2b_f3_dout", {16'h0000, dout}, 32'h0000D234);

        // Bad header 2'b10 while locked.
        np = 0;
        f = 16'h8123;
        for (int i = 0; i < 16; i++) begin
            step(f[15-i], 1'b1);
            if (dout_valid) np++;
            if (i == 0) chk("bad_hdr_no_err_bit1", {31'h0, frame_err}, 32'h0);
            if (i == 1) begin
                chk("bad_hdr_err", {31'h0, frame_err}, 32'h1);
                chk("bad_hdr_unlock", {31'h0, sync_locked}, 32'h0);
            end
        end
        chk("bad_hdr_no_pulse", np, 0);

        // Reset in the middle of a frame, then a clean frame.
        f = 16'hCAFE;
        for (int i = 0; i < 9; i++) step(f[15-i], 1'b1);
        do_reset();
        send_frame(16'hC0DE, -1, 0, fp, np);
        chk("rst_mid_lat", fp, 16);
        chk("rst_mid_npulse", np, 1);
        chk("rst_mid_dout", {16'h0000, dout}, 32'h0000C0DE);

        // Isolated valid one falls back to hunting.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("iso_no_err", {31'h0, frame_err}, 32'h0);
        send_frame(16'hC5A3, -1, 0, fp, np);
        chk("iso_realign_lat", fp, 16);

        // Randomized framed traffic with stalls, junk bits and corrupt headers.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            f = {2'b11, r[13:0]};
            if ($urandom_range(5, 0) == 0) begin
                r = $urandom;
                f[15:14] = r[1:0];
            end
            if ($urandom_range(9, 0) == 0) step(1'($urandom), 1'b1);
            for (int i = 0; i < 16; i++) begin
                while ($urandom_range(3, 0) == 0) step(1'($urandom), 1'b0);
                step(f[15-i], 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
